// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bundle: the instruction-memory request/response bus plus the
// held-instruction interface to the controller/datapath.
interface instr_fetch_unit_if #(
  parameter int XLEN = 32
);
  // Handshakes: a request transfers on a rising edge where imem_req_valid && imem_req_ready;
  // valid never depends on ready, and addr stays stable while valid is high and ready is low.
  // The response has no back-pressure; it is taken on the edge where imem_rsp_valid is high.
  // The held instruction retires on the edge where instr_valid && instr_ready.
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rdata;
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     Instr;
  logic [XLEN-1:0] PC;
  logic [XLEN-1:0] PCPlus4;
  logic [6:0]      op;
  logic [2:0]      funct3;
  logic            funct7b5;
  logic            PCSrc;
  logic [XLEN-1:0] PCTarget;

  modport master (
    output imem_req_valid, imem_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rdata,
    output instr_valid, Instr, PC, PCPlus4, op, funct3, funct7b5,
    input  instr_ready, PCSrc, PCTarget
  );

  modport slave (
    input  imem_req_valid, imem_addr,
    output imem_req_ready, imem_rsp_valid, imem_rdata,
    input  instr_valid, Instr, PC, PCPlus4, op, funct3, funct7b5,
    output instr_ready, PCSrc, PCTarget
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, keeps one instruction-memory request outstanding,
// holds the fetched word for decode and redirects on retire.
module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_unit_if.master  bus,
  output logic                fetch_fault,
  output logic [31:0]         retire_count,
  output logic [1:0]          o_dbg_state
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t          r_state;
  state_t          w_next_state;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_instr;
  logic            r_fault;
  logic [31:0]     r_retire_cnt;

  logic            w_req_valid;
  logic            w_instr_valid;
  logic            w_retire;
  logic            w_misaligned;
  logic            w_take_rsp;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_next_pc;

  assign w_pc_plus4   = r_pc + XLEN'(4);
  assign w_next_pc    = bus.PCSrc ? bus.PCTarget : w_pc_plus4;
  assign w_misaligned = bus.PCSrc && (bus.PCTarget[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state  = r_state;
    w_req_valid   = 1'b0;
    w_instr_valid = 1'b0;
    w_retire      = 1'b0;
    w_take_rsp    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_req_valid = 1'b1;
        if (bus.imem_req_ready) w_next_state = S_WAIT;
      end
      S_WAIT: begin
        if (bus.imem_rsp_valid) begin
          w_take_rsp   = 1'b1;
          w_next_state = S_VALID;
        end
      end
      S_VALID: begin
        w_instr_valid = 1'b1;
        if (bus.instr_ready) begin
          w_retire     = 1'b1;
          w_next_state = w_misaligned ? S_FAULT : S_FETCH;
        end
      end
      default: w_next_state = S_FAULT;
    endcase
  end

  // A misaligned redirect still counts as a retire but leaves the PC on the offender.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc         <= RESET_PC;
      r_instr      <= NOP;
      r_fault      <= 1'b0;
      r_retire_cnt <= '0;
    end else begin
      if (w_take_rsp) r_instr <= bus.imem_rdata;
      if (w_retire) begin
        r_retire_cnt <= r_retire_cnt + 32'd1;
        if (w_misaligned) r_fault <= 1'b1;
        else              r_pc    <= w_next_pc;
      end
    end
  end

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_addr      = r_pc;
  assign bus.instr_valid    = w_instr_valid;
  assign bus.Instr          = r_instr;
  assign bus.PC             = r_pc;
  assign bus.PCPlus4        = w_pc_plus4;
  assign bus.op             = r_instr[6:0];
  assign bus.funct3         = r_instr[14:12];
  assign bus.funct7b5       = r_instr[30];
  assign fetch_fault        = r_fault;
  assign retire_count       = r_retire_cnt;
  assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a randomized
// fetch/retire run checked against a transaction-level PC/instruction model.
module tb_instr_fetch_unit;
  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_fault;
  logic [31:0] retire_count;
  logic [1:0]  dbg_state;

  instr_fetch_unit_if #(.XLEN(XLEN)) bus ();

  instr_fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.master),
    .fetch_fault  (fetch_fault),
    .retire_count (retire_count),
    .o_dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_fault;
  logic [31:0] m_instr;
  logic [31:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_cnt = 0; m_fault = 1'b0; m_instr = NOP;
    exp_q.delete();
  endtask

  task automatic idle_inputs();
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rdata = 32'h0;
    bus.instr_ready = 1'b0; bus.PCSrc = 1'b0; bus.PCTarget = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) tick();
    reset = 1'b0;
    model_reset();
  endtask

  // Waits for a request, optionally stalls it, accepts it; reports the accepted address.
  task automatic accept_only(input int ready_delay, output logic [31:0] acc_addr,
                             output bit stable, output bit ok);
    int n = 0;
    logic [31:0] first;
    ok = 1'b1; stable = 1'b1; acc_addr = 32'hx;
    while (bus.imem_req_valid !== 1'b1 && n < 20) begin tick(); n++; end
    if (bus.imem_req_valid !== 1'b1) begin ok = 1'b0; return; end
    first = bus.imem_addr;
    repeat (ready_delay) begin
      tick();
      if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== first) stable = 1'b0;
    end
    acc_addr = bus.imem_addr;
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
  endtask

  // Full fetch: accept, then respond rsp_delay cycles later with word.
  task automatic serve_fetch(input int ready_delay, input int rsp_delay, input logic [31:0] word,
                             output logic [31:0] acc_addr, output bit stable,
                             output bit req_dropped, output bit ok);
    accept_only(ready_delay, acc_addr, stable, ok);
    req_dropped = 1'b0;
    if (!ok) return;
    req_dropped = (bus.imem_req_valid === 1'b0);
    repeat (rsp_delay) begin
      bus.instr_ready = 1'($urandom_range(0, 1));
      tick();
      if (bus.imem_req_valid !== 1'b0) req_dropped = 1'b0;
    end
    bus.instr_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rdata = word;
    tick();
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rdata = $urandom;
    exp_q.push_back(word);
  endtask

  task automatic retire(input logic src, input logic [31:0] tgt);
    bus.instr_ready = 1'b1; bus.PCSrc = src; bus.PCTarget = tgt;
    tick();
    bus.instr_ready = 1'b0; bus.PCSrc = 1'($urandom_range(0, 1)); bus.PCTarget = $urandom;
    m_cnt = m_cnt + 1;
    if (src && tgt[1:0] != 2'b00) m_fault = 1'b1;
    else m_pc = src ? tgt : m_pc + 32'd4;
  endtask

  // ---------------- test tasks ----------------
  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    model_reset();
    tick();
    n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_instr_valid: got %b want 0", bus.instr_valid); end
    n_cmp++; if (bus.Instr !== NOP) begin n_err++; $display("FAIL rst_instr: got %h want %h", bus.Instr, NOP); end
    n_cmp++; if (bus.PC !== RESET_PC) begin n_err++; $display("FAIL rst_pc: got %h want %h", bus.PC, RESET_PC); end
    n_cmp++; if (fetch_fault !== 1'b0) begin n_err++; $display("FAIL rst_fault: got %b want 0", fetch_fault); end
    n_cmp++; if (retire_count !== 32'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", retire_count); end
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.imem_req_valid !== 1'b1) begin n_err++; $display("FAIL rst_req_valid: got %b want 1", bus.imem_req_valid); end
    n_cmp++; if (bus.imem_addr !== RESET_PC) begin n_err++; $display("FAIL rst_addr: got %h want %h", bus.imem_addr, RESET_PC); end
  endtask

  task automatic test_sequential_and_branch();
    logic [31:0] acc, w;
    bit stable, dropped, ok;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      serve_fetch(0, 0, w, acc, stable, dropped, ok);
      n_cmp++; if (!ok || acc !== 32'(i * 4)) begin n_err++; $display("FAIL seq_addr%0d: got %h want %h", i, acc, 32'(i * 4)); end
      n_cmp++; if (bus.Instr !== exp_q.pop_front() || bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL seq_instr%0d: got %h/%b want %h/1", i, bus.Instr, bus.instr_valid, w); end
      m_instr = w;
      if (i == 2) begin
        n_cmp++; if (bus.PC !== 32'h8) begin n_err++; $display("FAIL seq_pc8: got %h want 00000008", bus.PC); end
        retire(1'b1, 32'h40);
      end else begin
        retire(1'b0, 32'h0);
        n_cmp++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== m_pc) begin n_err++; $display("FAIL seq_next_req%0d: got %b/%h want 1/%h", i, bus.imem_req_valid, bus.imem_addr, m_pc); end
      end
    end
    n_cmp++; if (retire_count !== 32'd3) begin n_err++; $display("FAIL seq_count: got %0d want 3", retire_count); end
    n_cmp++; if (bus.imem_addr !== 32'h40) begin n_err++; $display("FAIL br_addr: got %h want 00000040", bus.imem_addr); end
    n_cmp++; if (bus.PCPlus4 !== 32'h44) begin n_err++; $display("FAIL br_pcplus4: got %h want 00000044", bus.PCPlus4); end
  endtask

  task automatic test_stall();
    logic [31:0] acc, w;
    bit stable, dropped, ok;
    w = $urandom;
    serve_fetch(3, 1, w, acc, stable, dropped, ok);
    n_cmp++; if (!ok || !stable) begin n_err++; $display("FAIL stall_stable: got ok=%b stable=%b want 1/1", ok, stable); end
    n_cmp++; if (acc !== m_pc) begin n_err++; $display("FAIL stall_addr: got %h want %h", acc, m_pc); end
    n_cmp++; if (!dropped) begin n_err++; $display("FAIL stall_one_accept: req_valid seen high after accept, want 0"); end
    n_cmp++; if (bus.Instr !== exp_q.pop_front()) begin n_err++; $display("FAIL stall_instr: got %h want %h", bus.Instr, w); end
    m_instr = w;
    retire(1'b0, 32'h0);
    n_cmp++; if (bus.imem_addr !== m_pc) begin n_err++; $display("FAIL stall_next_addr: got %h want %h", bus.imem_addr, m_pc); end
  endtask

  task automatic test_spurious();
    bus.imem_rsp_valid = 1'b1; bus.imem_rdata = 32'hDEADBEEF; bus.instr_ready = 1'b1;
    repeat (2) tick();
    idle_inputs();
    n_cmp++; if (bus.Instr !== m_instr) begin n_err++; $display("FAIL spur_instr: got %h want %h", bus.Instr, m_instr); end
    n_cmp++; if (retire_count !== m_cnt) begin n_err++; $display("FAIL spur_count: got %0d want %0d", retire_count, m_cnt); end
    n_cmp++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== m_pc) begin n_err++; $display("FAIL spur_req: got %b/%h want 1/%h", bus.imem_req_valid, bus.imem_addr, m_pc); end
  endtask

  task automatic test_wrap();
    logic [31:0] acc, w;
    bit stable, dropped, ok;
    w = $urandom;
    serve_fetch(0, 0, w, acc, stable, dropped, ok);
    void'(exp_q.pop_front());
    retire(1'b1, 32'hFFFF_FFFC);
    serve_fetch(0, 0, w, acc, stable, dropped, ok);
    void'(exp_q.pop_front());
    m_instr = w;
    n_cmp++; if (!ok || acc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_addr: got %h want fffffffc", acc); end
    n_cmp++; if (bus.PCPlus4 !== 32'h0) begin n_err++; $display("FAIL wrap_pcplus4: got %h want 00000000", bus.PCPlus4); end
    retire(1'b0, 32'h0);
    n_cmp++; if (bus.imem_addr !== 32'h0 || bus.imem_req_valid !== 1'b1) begin n_err++; $display("FAIL wrap_next: got %b/%h want 1/00000000", bus.imem_req_valid, bus.imem_addr); end
    n_cmp++; if (fetch_fault !== 1'b0) begin n_err++; $display("FAIL wrap_fault: got %b want 0", fetch_fault); end
  endtask

  task automatic test_random();
    logic [31:0] acc, w, tgt, exp_w;
    bit stable, dropped, ok, src;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      w = $urandom;
      serve_fetch($urandom_range(0, 3), $urandom_range(0, 3), w, acc, stable, dropped, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL rnd_timeout%0d: no request within 20 cycles", i); return; end
      exp_w = exp_q.pop_front();
      m_instr = exp_w;
      n_cmp++; if (acc !== m_pc || !stable) begin n_err++; $display("FAIL rnd_addr%0d: got %h stable=%b want %h", i, acc, stable, m_pc); end
      repeat ($urandom_range(0, 2)) tick();
      n_cmp++; if (bus.instr_valid !== 1'b1 || bus.Instr !== exp_w) begin n_err++; $display("FAIL rnd_instr%0d: got %b/%h want 1/%h", i, bus.instr_valid, bus.Instr, exp_w); end
      n_cmp++; if (bus.PC !== m_pc || bus.PCPlus4 !== m_pc + 32'd4) begin n_err++; $display("FAIL rnd_pc%0d: got %h/%h want %h/%h", i, bus.PC, bus.PCPlus4, m_pc, m_pc + 32'd4); end
      n_cmp++; if (bus.op !== exp_w[6:0] || bus.funct3 !== exp_w[14:12] || bus.funct7b5 !== exp_w[30]) begin n_err++; $display("FAIL rnd_fields%0d: got %h/%h/%b from %h", i, bus.op, bus.funct3, bus.funct7b5, exp_w); end
      src = ($urandom_range(0, 3) == 0);
      tgt = $urandom & 32'hFFFF_FFFC;
      retire(src, tgt);
      n_cmp++; if (retire_count !== m_cnt || fetch_fault !== 1'b0) begin n_err++; $display("FAIL rnd_count%0d: got %0d/%b want %0d/0", i, retire_count, fetch_fault, m_cnt); end
      n_cmp++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== m_pc) begin n_err++; $display("FAIL rnd_next%0d: got %b/%h want 1/%h", i, bus.imem_req_valid, bus.imem_addr, m_pc); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] acc, w;
    bit stable, dropped, ok;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      serve_fetch(0, 0, w, acc, stable, dropped, ok);
      void'(exp_q.pop_front());
      retire(1'b0, 32'h0);
    end
    accept_only(0, acc, stable, ok);
    n_cmp++; if (acc !== 32'h10 || bus.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL mid_wait: got %h/%b want 00000010/0", acc, bus.imem_req_valid); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (bus.PC !== RESET_PC || retire_count !== 32'd0 || bus.Instr !== NOP) begin n_err++; $display("FAIL mid_reset: got pc=%h cnt=%0d instr=%h want %h/0/%h", bus.PC, retire_count, bus.Instr, RESET_PC, NOP); end
    bus.imem_rsp_valid = 1'b1; bus.imem_rdata = $urandom;
    tick();
    bus.imem_rsp_valid = 1'b0;
    reset = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (bus.instr_valid !== 1'b0 || bus.Instr !== NOP) begin n_err++; $display("FAIL mid_dropped: got %b/%h want 0/%h", bus.instr_valid, bus.Instr, NOP); end
    n_cmp++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== RESET_PC) begin n_err++; $display("FAIL mid_refetch: got %b/%h want 1/%h", bus.imem_req_valid, bus.imem_addr, RESET_PC); end
  endtask

  task automatic test_fault();
    logic [31:0] acc, w, old_pc, held;
    bit stable, dropped, ok;
    w = $urandom;
    serve_fetch(0, 0, w, acc, stable, dropped, ok);
    void'(exp_q.pop_front());
    retire(1'b0, 32'h0);
    serve_fetch(1, 0, w, acc, stable, dropped, ok);
    void'(exp_q.pop_front());
    old_pc = m_pc;
    held = w;
    retire(1'b1, 32'h42);
    n_cmp++; if (fetch_fault !== 1'b1) begin n_err++; $display("FAIL fault_flag: got %b want 1", fetch_fault); end
    n_cmp++; if (bus.PC !== old_pc || retire_count !== m_cnt) begin n_err++; $display("FAIL fault_pc: got %h/%0d want %h/%0d", bus.PC, retire_count, old_pc, m_cnt); end
    bus.imem_req_ready = 1'b1; bus.imem_rsp_valid = 1'b1; bus.instr_ready = 1'b1; bus.imem_rdata = $urandom;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (bus.imem_req_valid !== 1'b0 || bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL fault_quiet%0d: got %b/%b want 0/0", i, bus.imem_req_valid, bus.instr_valid); end
      tick();
    end
    n_cmp++; if (retire_count !== m_cnt || bus.Instr !== held || bus.PC !== old_pc) begin n_err++; $display("FAIL fault_hold: got %0d/%h/%h want %0d/%h/%h", retire_count, bus.Instr, bus.PC, m_cnt, held, old_pc); end
    do_reset();
    n_cmp++; if (fetch_fault !== 1'b0 || bus.imem_req_valid !== 1'b1) begin n_err++; $display("FAIL fault_cleared: got %b/%b want 0/1", fetch_fault, bus.imem_req_valid); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_sequential_and_branch();
    test_stall();
    test_spurious();
    test_wrap();
    test_random();
    test_reset_mid();
    test_fault();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
